aer_encoder: RTL and testbench
==============================

Name: aer_encoder

Overview:
- Transmit-side AER block: converts per-channel spike pulses into 24-bit address-event words {channel[3:0], timestamp[19:0]} for the AER receive pipeline.
- Samples a spike vector and stamps each event with a free-running 20-bit tick counter.
- Arbitrates simultaneous events round-robin, buffers them in a FIFO, and drives data/aer_valid under a ready handshake.

Parameters:
- NUM_CH, 16: number of spike channels. Must equal 2^CH_W.
- CH_W, 4: channel-id width, packed into data[23:20].
- TS_W, 20: timestamp width, packed into data[19:0].
- FIFO_DEPTH, 16: event FIFO entries. Power of 2, at least 2.
- TS_DIV, 1: clk cycles per timestamp tick. At least 1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- spike_in  input  NUM_CH  per-channel spike pulses, sampled every cycle
- aer_ready  input  1  downstream accepts the word this cycle
- data  output  CH_W+TS_W (24)  event word {ch, ts}
- aer_valid  output  1  data holds a valid event
- ts_now  output  TS_W  current timestamp counter value
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries
- fifo_empty  output  1  FIFO holds 0 entries
- drop_count  output  16  saturating count of lost spikes

Behaviour:
- Reset (rst=1 at an edge) clears the following:
  - ts_now=0, prescaler=0
  - pending=0, all captured timestamps=0
  - rr_ptr=0
  - FIFO pointers and count=0
  - data=0, aer_valid=0, fifo_empty=1, fifo_full=0, drop_count=0
  - Reset mid-operation discards all pending and queued events. Outputs hold reset values from the following cycle.
- Timestamp counter:
  - Prescaler counts 0..TS_DIV-1.
  - ts_now increments when the prescaler wraps; with TS_DIV=1 it increments every cycle.
  - ts_now wraps 2^TS_W-1 -> 0 with no flag.
- Capture, per channel i, per cycle:
  - spike_in[i]=1 and pending[i]=0: set pending[i], ts_cap[i] <= ts_now (value before this edge's increment).
  - spike_in[i]=1 and pending[i]=1 and i not granted this cycle: spike dropped, drop_count++. The original ts_cap[i] is kept.
  - spike_in[i]=1 and i granted this cycle: the grant clears the old event and the new spike re-sets pending[i] with the new ts_now. No drop.
  - Multiple channels spiking in the same cycle are all captured independently.
- Arbiter, combinational grant, registered effect:
  - A grant occurs only when pending != 0 and fifo_full=0, where fifo_full is the value before this cycle's pop.
  - Search order: rr_ptr, rr_ptr+1, ... mod NUM_CH. The first pending channel g is granted.
  - At the edge: push {g[CH_W-1:0], ts_cap[g]}, clear pending[g], rr_ptr <= g+1 mod NUM_CH.
  - At most one grant per cycle.
  - While fifo_full=1, no grant occurs and pending events are held. New spikes on already-pending channels are counted as drops.
- FIFO and output (first-word-fall-through):
  - data = head entry, aer_valid = !fifo_empty.
  - Pop occurs when aer_valid && aer_ready.
  - data must be stable while aer_valid=1 and aer_ready=0.
  - Push and pop in the same cycle: count unchanged, both take effect.
  - Pop when empty: ignored.
  - Words are delivered in grant order.
- Latency:
  - spike_in high in cycle C with the block idle: pending set at the end of C, grant in C+1, aer_valid=1 in C+2.
  - data timestamp = ts_now value in cycle C.
- drop_count saturates at 16'hFFFF.

Test Plan:
- Reset, then spike_in=16'h0400 in one cycle with ts_now=5 and aer_ready=1 -> two cycles later aer_valid=1 for one cycle, data=24'hA00005, then fifo_empty=1.
- spike_in=16'h000F in one cycle with ts_now=T and aer_ready=1 -> four consecutive words with channels 0,1,2,3, each ts=T; rr_ptr ends at 4.
- aer_ready=0, a new channel spike every cycle (ch0..15, then ch0..3 again) -> fifo_full=1 after 16 pushes; later channels stay pending; repeat spikes on pending channels increment drop_count (expect 3); data stable throughout. Then aer_ready=1 -> all remaining events drain in order.
- TS_DIV=4, ts_now preloaded near wrap (run 2^20 ticks) -> ts_now goes 20'hFFFFF -> 0; an event captured at each value carries 20'hFFFFF and 20'h00000 respectively.
- Spike on ch7 in the same cycle ch7 is granted -> two ch7 words out, second with the later timestamp, drop_count unchanged.
- Assert rst while 5 events are queued and 3 are pending -> the next cycle shows aer_valid=0, fifo_empty=1, drop_count=0, ts_now=0, and no stale words afterwards.

Source files
------------

// File: rtl/aer_if.sv
// Address-event output handshake: event word plus valid/ready.
interface aer_if #(
    parameter int W = 24
);
    logic [W-1:0] data;
    logic         aer_valid;
    logic         aer_ready;

    modport master (output data, output aer_valid, input aer_ready);
    modport slave  (input data, input aer_valid, output aer_ready);
endinterface

// File: rtl/aer_encoder.sv
// Transmit-side AER encoder: captures per-channel spikes with a timestamp,
// arbitrates round-robin into an event FIFO, and presents FWFT words
// {channel, timestamp} under a valid/ready handshake.
module aer_encoder #(
    parameter int NUM_CH     = 16,
    parameter int CH_W       = 4,
    parameter int TS_W       = 20,
    parameter int FIFO_DEPTH = 16,
    parameter int TS_DIV     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] spike_in,
    aer_if.master             aer,
    output logic [TS_W-1:0]   ts_now,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [15:0]       drop_count
);
    localparam int W  = CH_W + TS_W;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;

    logic [PW-1:0]                presc;
    logic                         tick;
    logic [NUM_CH-1:0]            pending;
    logic [NUM_CH-1:0]            pending_nxt;
    logic [NUM_CH-1:0]            take_vec;
    logic [NUM_CH-1:0]            drop_vec;
    logic [NUM_CH-1:0]            gnt_mask;
    logic [NUM_CH-1:0][TS_W-1:0]  ts_cap;
    logic [CH_W-1:0]              rr_ptr;
    logic [CH_W-1:0]              gnt_ch;
    logic [CH_W-1:0]              scan_idx;
    logic                         gnt_vld;
    logic [CH_W:0]                ndrop;
    logic [16:0]                  drop_sum;

    logic [W-1:0]                 mem [FIFO_DEPTH];
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [AW:0]                  count;
    logic                         push;
    logic                         pop;

    // Prescaled free-running timestamp; wraps silently.
    assign tick = (presc == PW'(TS_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc  <= '0;
            ts_now <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick)
                ts_now <= ts_now + TS_W'(1);
        end
    end

    // Round-robin search from rr_ptr; the lowest offset pending channel wins.
    // Granting is suppressed while the FIFO is full (pre-pop occupancy).
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_ch   = '0;
        scan_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            scan_idx = rr_ptr + CH_W'(k);
            if (pending[scan_idx] && !fifo_full) begin
                gnt_vld = 1'b1;
                gnt_ch  = scan_idx;
            end
        end
    end

    assign gnt_mask = gnt_vld ? (NUM_CH'(1) << gnt_ch) : '0;

    // A spike is captured if the channel is free or is being granted now;
    // otherwise it collides with a held event and is counted as lost.
    always_comb begin
        take_vec    = spike_in & (~pending | gnt_mask);
        drop_vec    = spike_in & pending & ~gnt_mask;
        pending_nxt = (pending & ~gnt_mask) | spike_in;
        ndrop       = '0;
        for (int i = 0; i < NUM_CH; i++)
            ndrop = ndrop + (CH_W + 1)'(drop_vec[i]);
        drop_sum = {1'b0, drop_count} + 17'(ndrop);
    end

    // Pending flags, captured timestamps, arbiter pointer and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            ts_cap     <= '0;
            rr_ptr     <= '0;
            drop_count <= '0;
        end else begin
            pending <= pending_nxt;
            for (int i = 0; i < NUM_CH; i++)
                if (take_vec[i])
                    ts_cap[i] <= ts_now;
            if (gnt_vld)
                rr_ptr <= gnt_ch + CH_W'(1);
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign push = gnt_vld;
    assign pop  = !fifo_empty && aer.aer_ready;

    // Event storage; contents need no reset since occupancy gates the output.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {gnt_ch, ts_cap[gnt_ch]};
    end

    // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW + 1)'(1);
            else if (pop && !push)
                count <= count - (AW + 1)'(1);
        end
    end

    assign fifo_empty    = (count == '0);
    assign fifo_full     = (count == (AW + 1)'(FIFO_DEPTH));
    assign aer.aer_valid = !fifo_empty;
    assign aer.data      = fifo_empty ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_aer_encoder.sv
// Directed bench for aer_encoder: single event, round-robin burst, FIFO
// back-pressure with drops, same-cycle re-spike, mid-run reset, and
// timestamp wrap on a narrow-timestamp instance with TS_DIV=4.
module tb_aer_encoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] spike;
    logic [19:0] ts_now;
    logic        full, empty;
    logic [15:0] drops;

    logic        rst_s;
    logic [15:0] spike_s;
    logic [7:0]  ts_s;
    logic        full_s, empty_s;
    logic [15:0] drops_s;

    aer_if #(.W(24)) bus ();
    aer_if #(.W(12)) bus_s ();

    aer_encoder #(.NUM_CH(16), .CH_W(4), .TS_W(20), .FIFO_DEPTH(16), .TS_DIV(1)) dut (
        .clk(clk), .rst(rst), .spike_in(spike), .aer(bus), .ts_now(ts_now),
        .fifo_full(full), .fifo_empty(empty), .drop_count(drops)
    );

    // Narrow timestamp so the wrap is reachable in about a thousand cycles.
    aer_encoder #(.NUM_CH(16), .CH_W(4), .TS_W(8), .FIFO_DEPTH(4), .TS_DIV(4)) dut_s (
        .clk(clk), .rst(rst_s), .spike_in(spike_s), .aer(bus_s), .ts_now(ts_s),
        .fifo_full(full_s), .fifo_empty(empty_s), .drop_count(drops_s)
    );

    int tests = 0;
    int fails = 0;

    // Reference tick count for the TS_DIV=1 instance.
    logic [19:0] ts_model;
    always @(posedge clk) ts_model <= rst ? 20'd0 : ts_model + 20'd1;

    task automatic test_reset();
        rst = 1'b1;
        spike = '0;
        bus.aer_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (ts_now !== 20'd0) begin fails++; $display("FAIL reset_ts got=%h exp=0", ts_now); end
        tests++; if (bus.aer_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", bus.aer_valid); end
        tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", empty, full); end
        tests++; if (drops !== 16'd0) begin fails++; $display("FAIL reset_drops got=%0d exp=0", drops); end
        tests++; if (bus.data !== 24'd0) begin fails++; $display("FAIL reset_data got=%h exp=0", bus.data); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        repeat (5) @(negedge clk);
        tests++; if (ts_now !== 20'd5) begin fails++; $display("FAIL single_ts got=%h exp=5", ts_now); end
        spike = 16'h0400;
        @(negedge clk);
        spike = '0;
        tests++; if (bus.aer_valid !== 1'b0) begin fails++; $display("FAIL single_early got=%b exp=0", bus.aer_valid); end
        @(negedge clk);
        tests++; if (bus.aer_valid !== 1'b1 || bus.data !== 24'hA00005) begin
            fails++; $display("FAIL single_word valid=%b data=%h exp 1/a00005", bus.aer_valid, bus.data); end
        @(negedge clk);
        tests++; if (bus.aer_valid !== 1'b0 || empty !== 1'b1) begin
            fails++; $display("FAIL single_after valid=%b empty=%b exp 0/1", bus.aer_valid, empty); end
    endtask

    task automatic test_round_robin();
        logic [19:0] t;
        @(negedge clk);
        t = ts_model;
        spike = 16'h000F;
        @(negedge clk);
        spike = '0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            tests++; if (bus.aer_valid !== 1'b1 || bus.data !== {4'(k), t}) begin
                fails++; $display("FAIL rr_word%0d valid=%b data=%h exp=%h", k, bus.aer_valid, bus.data, {4'(k), t}); end
            @(negedge clk);
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rr_empty got=%b exp=1", empty); end
    endtask

    task automatic test_fill_drop();
        logic [23:0] exp_q[$];
        int ch;
        int got;
        int rep [3] = '{1, 1, 2};
        bus.aer_ready = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (j == 16) begin
                tests++; if (full !== 1'b0) begin fails++; $display("FAIL fill_notfull got=%b exp=0", full); end
            end
            if (j == 17) begin
                tests++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full got=%b exp=1", full); end
            end
            if (j >= 2) begin
                tests++; if (bus.aer_valid !== 1'b1 || bus.data !== exp_q[0]) begin
                    fails++; $display("FAIL fill_stable%0d data=%h exp=%h", j, bus.data, exp_q[0]); end
            end
            ch = j % 16;
            spike = 16'd1 << ch;
            exp_q.push_back({4'(ch), ts_model});
        end
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            spike = 16'd1 << rep[r];
        end
        @(negedge clk);
        spike = '0;
        tests++; if (drops !== 16'd3) begin fails++; $display("FAIL fill_drops got=%0d exp=3", drops); end
        tests++; if (full !== 1'b1 || bus.data !== exp_q[0]) begin
            fails++; $display("FAIL fill_hold full=%b data=%h exp 1/%h", full, bus.data, exp_q[0]); end
        bus.aer_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 60; c++) begin
            if (bus.aer_valid === 1'b1) begin
                if (got < 20) begin
                    tests++; if (bus.data !== exp_q[got]) begin
                        fails++; $display("FAIL drain%0d got=%h exp=%h", got, bus.data, exp_q[got]); end
                end
                got++;
            end
            @(negedge clk);
        end
        tests++; if (got != 20 || empty !== 1'b1) begin
            fails++; $display("FAIL drain_count got=%0d empty=%b exp 20/1", got, empty); end
    endtask

    task automatic test_same_cycle_grant();
        logic [19:0] t;
        @(negedge clk);
        t = ts_model;
        spike = 16'h0080;
        @(negedge clk);
        spike = 16'h0080;
        @(negedge clk);
        spike = '0;
        tests++; if (bus.aer_valid !== 1'b1 || bus.data !== {4'h7, t}) begin
            fails++; $display("FAIL regrant_first data=%h exp=%h", bus.data, {4'h7, t}); end
        @(negedge clk);
        tests++; if (bus.aer_valid !== 1'b1 || bus.data !== {4'h7, t + 20'd1}) begin
            fails++; $display("FAIL regrant_second data=%h exp=%h", bus.data, {4'h7, t + 20'd1}); end
        @(negedge clk);
        tests++; if (empty !== 1'b1 || drops !== 16'd3) begin
            fails++; $display("FAIL regrant_end empty=%b drops=%0d exp 1/3", empty, drops); end
    endtask

    task automatic test_reset_midop();
        int stale;
        bus.aer_ready = 1'b0;
        @(negedge clk);
        spike = 16'h00FF;
        @(negedge clk);
        spike = '0;
        repeat (5) @(negedge clk);
        tests++; if (bus.aer_valid !== 1'b1 || full !== 1'b0) begin
            fails++; $display("FAIL midop_queued valid=%b full=%b exp 1/0", bus.aer_valid, full); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (bus.aer_valid !== 1'b0 || empty !== 1'b1 || drops !== 16'd0 || ts_now !== 20'd0 || bus.data !== 24'd0) begin
            fails++; $display("FAIL midop_reset valid=%b empty=%b drops=%0d ts=%h data=%h exp 0/1/0/0/0",
                              bus.aer_valid, empty, drops, ts_now, bus.data); end
        rst = 1'b0;
        bus.aer_ready = 1'b1;
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.aer_valid !== 1'b0) stale++;
        end
        tests++; if (stale != 0) begin fails++; $display("FAIL midop_stale got=%0d exp=0", stale); end
    endtask

    task automatic test_ts_wrap();
        int n;
        int hold;
        logic [11:0] q[$];
        bus_s.aer_ready = 1'b0;
        @(negedge clk);
        rst_s = 1'b0;
        n = 0;
        while (ts_s !== 8'hFF && n < 2000) begin
            @(negedge clk);
            n++;
        end
        tests++; if (ts_s !== 8'hFF) begin fails++; $display("FAIL wrap_reach got=%h exp=ff", ts_s); end
        spike_s = 16'h0008;
        hold = 0;
        while (ts_s === 8'hFF && hold < 10) begin
            @(negedge clk);
            spike_s = '0;
            hold++;
        end
        tests++; if (hold != 4 || ts_s !== 8'h00) begin
            fails++; $display("FAIL wrap_step hold=%0d ts=%h exp 4/00", hold, ts_s); end
        spike_s = 16'h0020;
        @(negedge clk);
        spike_s = '0;
        repeat (3) @(negedge clk);
        bus_s.aer_ready = 1'b1;
        repeat (6) begin
            if (bus_s.aer_valid === 1'b1) q.push_back(bus_s.data);
            @(negedge clk);
        end
        tests++; if (q.size() != 2) begin fails++; $display("FAIL wrap_count got=%0d exp=2", q.size()); end
        else begin
            tests++; if (q[0] !== 12'h3FF) begin fails++; $display("FAIL wrap_pre got=%h exp=3ff", q[0]); end
            tests++; if (q[1] !== 12'h500) begin fails++; $display("FAIL wrap_post got=%h exp=500", q[1]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        rst_s = 1'b1;
        spike = '0;
        spike_s = '0;
        bus.aer_ready = 1'b1;
        bus_s.aer_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_fill_drop();
        test_same_cycle_grant();
        test_reset_midop();
        test_ts_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
